// File: rtl/calc_pkg.sv
// Shared encodings for the calculator front-end sequencer: FSM states, modes,
// unary op codes and sizing helpers.
package calc_pkg;

  localparam int CALC_SW_W   = 16;
  localparam int CALC_DATA_W = 64;
  localparam int CHUNKS_MAX  = CALC_DATA_W / CALC_SW_W;

  localparam logic [2:0] ST_MODE   = 3'd0;
  localparam logic [2:0] ST_OP     = 3'd1;
  localparam logic [2:0] ST_SIZE   = 3'd2;
  localparam logic [2:0] ST_LOAD_A = 3'd3;
  localparam logic [2:0] ST_LOAD_B = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;
  localparam logic [2:0] ST_WAIT   = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  localparam logic [2:0] MODE_FP    = 3'd0;
  localparam logic [2:0] MODE_ARITH = 3'd1;
  localparam logic [2:0] MODE_BIT   = 3'd2;
  localparam logic [2:0] MODE_LOGIC = 3'd3;
  localparam logic [2:0] MODE_FETCH = 3'd4;
  localparam logic [2:0] MODE_STORE = 3'd5;

  localparam logic [2:0] OP_ARITH_LOG = 3'd4;
  localparam logic [2:0] OP_LOGIC_NOT = 3'd6;

  // Width of a counter/index able to address n distinct values (minimum 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_loader.sv
// Assembles one operand from SW_W-bit chunks; the top-level extension of the
// finished operand follows CALC_SEQ_SIGN_EXT_EN (sign) or zero-extends.
module chunk_loader
  import calc_pkg::*;
#(
  parameter int SW_W   = 16,
  parameter int DATA_W = 64,
  parameter int CW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [SW_W-1:0]   chunk,
  input  logic [CW:0]       nchunks,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  localparam int CHUNKS = DATA_W / SW_W;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] nxt;

  assign last = ({1'b0, cnt} == nchunks - 1'b1);

`ifdef CALC_SEQ_SIGN_EXT_EN
  function automatic logic [DATA_W-1:0] sext(input logic [DATA_W-1:0] v,
                                             input logic [CW:0]       n);
    logic              s;
    logic [DATA_W-1:0] r;
    s = 1'b0;
    r = v;
    for (int i = 0; i < CHUNKS; i++) begin
      if (n == (CW+1)'(i + 1)) s = v[i*SW_W + SW_W - 1];
      if ((CW+1)'(i) >= n) r[i*SW_W +: SW_W] = {SW_W{s}};
    end
    return r;
  endfunction
`endif

  always_comb begin
    nxt = data;
    for (int i = 0; i < CHUNKS; i++) begin
      if (cnt == CW'(i)) nxt[i*SW_W +: SW_W] = chunk;
    end
`ifdef CALC_SEQ_SIGN_EXT_EN
    if (last) nxt = sext(nxt, nchunks);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (wr) begin
      data <= nxt;
      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end sequencer: mode/op/size selection, chunked operand entry,
// exec start/done handshake with timeout, register-file store/fetch.
// Optional build macro CALC_SEQ_SIGN_EXT_EN sign-extends operands and fetched values.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int SW_W     = 16,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              confirm,
  input  logic [SW_W-1:0]   switches,
  output logic              exec_start,
  output logic [2:0]        exec_mode,
  output logic [2:0]        exec_op,
  output logic [DATA_W-1:0] opa,
  output logic [DATA_W-1:0] opb,
  input  logic              exec_done,
  input  logic [DATA_W-1:0] exec_result,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              sign,
  output logic              error,
  output logic              busy
);

  localparam int CHUNKS = DATA_W / SW_W;
  localparam int CW     = idx_w(CHUNKS);
  localparam int IW     = idx_w(NUM_REGS);
  localparam int TW     = idx_w(TIMEOUT);

  logic [2:0]        state;
  logic [CW:0]       nchunks;
  logic [CW:0]       nsel;
  logic [TW-1:0]     tcnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] fetch_val;
  logic [DATA_W-1:0] res_done;
  logic              a_last, b_last, unary, regop;

  function automatic logic [DATA_W-1:0] mask_act(input logic [DATA_W-1:0] v,
                                                 input logic [CW:0]       n);
    logic [DATA_W-1:0] r;
    r = v;
    for (int i = 0; i < CHUNKS; i++) begin
      if ((CW+1)'(i) >= n) r[i*SW_W +: SW_W] = '0;
    end
    return r;
  endfunction

  function automatic logic msb_act(input logic [DATA_W-1:0] v, input logic [CW:0] n);
    logic s;
    s = 1'b0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (n == (CW+1)'(i + 1)) s = v[i*SW_W + SW_W - 1];
    end
    return s;
  endfunction

`ifdef CALC_SEQ_SIGN_EXT_EN
  function automatic logic [DATA_W-1:0] sext_act(input logic [DATA_W-1:0] v,
                                                 input logic [CW:0]       n);
    logic              s;
    logic [DATA_W-1:0] r;
    s = msb_act(v, n);
    r = v;
    for (int i = 0; i < CHUNKS; i++) begin
      if ((CW+1)'(i) >= n) r[i*SW_W +: SW_W] = {SW_W{s}};
    end
    return r;
  endfunction
`endif

  generate
    if (IW <= 3) begin : g_idx_narrow
      assign idx = exec_op[IW-1:0];
    end else begin : g_idx_wide
      assign idx = {{(IW-3){1'b0}}, exec_op};
    end
  endgenerate

  assign busy       = (state == ST_EXEC) || (state == ST_WAIT);
  assign exec_start = (state == ST_EXEC);
  assign regop      = (exec_mode == MODE_FETCH) || (exec_mode == MODE_STORE);
  assign unary      = ((exec_mode == MODE_ARITH) && (exec_op == OP_ARITH_LOG)) ||
                      ((exec_mode == MODE_LOGIC) && (exec_op == OP_LOGIC_NOT));

  // Requested chunk count, clamped to what DATA_W can hold.
  always_comb begin
    nsel = (CW+1)'(CHUNKS);
    if (int'(switches[1:0]) < CHUNKS) nsel = (CW+1)'(switches[1:0]) + 1'b1;
  end

  always_comb begin
`ifdef CALC_SEQ_SIGN_EXT_EN
    fetch_val = sext_act(mask_act(regs[idx], nchunks), nchunks);
`else
    fetch_val = mask_act(regs[idx], nchunks);
`endif
    case (exec_mode)
      MODE_FETCH: res_done = fetch_val;
      MODE_STORE: res_done = opa;
      default:    res_done = result;
    endcase
  end

  chunk_loader #(.SW_W(SW_W), .DATA_W(DATA_W), .CW(CW)) u_load_a (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == ST_SIZE) && confirm),
    .wr      ((state == ST_LOAD_A) && confirm),
    .chunk   (switches),
    .nchunks (nchunks),
    .data    (opa),
    .last    (a_last)
  );

  chunk_loader #(.SW_W(SW_W), .DATA_W(DATA_W), .CW(CW)) u_load_b (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state == ST_SIZE) && confirm),
    .wr      ((state == ST_LOAD_B) && confirm),
    .chunk   (switches),
    .nchunks (nchunks),
    .data    (opb),
    .last    (b_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_MODE;
      exec_mode    <= '0;
      exec_op      <= '0;
      nchunks      <= '0;
      tcnt         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      sign         <= 1'b0;
      error        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_MODE: if (confirm) begin
          if (switches[2:0] > MODE_STORE) begin
            error <= 1'b1;
          end else begin
            error     <= 1'b0;
            exec_mode <= switches[2:0];
            state     <= ST_OP;
          end
        end
        ST_OP: if (confirm) begin
          exec_op <= switches[2:0];
          state   <= ST_SIZE;
        end
        ST_SIZE: if (confirm) begin
          nchunks <= nsel;
          state   <= ST_LOAD_A;
        end
        ST_LOAD_A: if (confirm && a_last) begin
          if (regop)      state <= ST_DONE;
          else if (unary) state <= ST_EXEC;
          else            state <= ST_LOAD_B;
        end
        ST_LOAD_B: if (confirm && b_last) state <= ST_EXEC;
        ST_EXEC: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        // Completion or timeout abort; a late done after abort is ignored.
        ST_WAIT: begin
          if (exec_done) begin
            result <= mask_act(exec_result, nchunks);
            state  <= ST_DONE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= ST_MODE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (exec_mode == MODE_STORE) regs[idx] <= opa;
          result       <= res_done;
          sign         <= msb_act(res_done, nchunks);
          result_valid <= 1'b1;
          state        <= ST_MODE;
        end
        default: state <= ST_MODE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer; expectations follow CALC_SEQ_SIGN_EXT_EN.
module tb_calc_sequencer;

  localparam int TO = 32;

  logic        clk, rst, confirm, exec_done;
  logic [15:0] switches;
  logic [63:0] exec_result;
  logic        exec_start, result_valid, sign, error, busy;
  logic [2:0]  exec_mode, exec_op;
  logic [63:0] opa, opb, result;

  typedef struct {
    logic [63:0] res;
    logic        sgn;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_start = 0;

  calc_sequencer #(.SW_W(16), .DATA_W(64), .NUM_REGS(4), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .confirm      (confirm),
    .switches     (switches),
    .exec_start   (exec_start),
    .exec_mode    (exec_mode),
    .exec_op      (exec_op),
    .opa          (opa),
    .opb          (opb),
    .exec_done    (exec_done),
    .exec_result  (exec_result),
    .result       (result),
    .result_valid (result_valid),
    .sign         (sign),
    .error        (error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] act16(input logic [15:0] v);
`ifdef CALC_SEQ_SIGN_EXT_EN
    return {{48{v[15]}}, v};
`else
    return {48'h0, v};
`endif
  endfunction

  task automatic push(input logic [63:0] r, input logic s);
    exp_t e;
    e.res = r;
    e.sgn = s;
    sbq.push_back(e);
  endtask

  task automatic press(input logic [15:0] v);
    @(negedge clk);
    switches = v;
    confirm  = 1'b1;
    @(negedge clk);
    confirm  = 1'b0;
  endtask

  task automatic setup(input logic [15:0] m, input logic [15:0] o, input logic [15:0] s);
    press(m);
    press(o);
    press(s);
  endtask

  task automatic done_pulse(input logic [63:0] v);
    @(negedge clk);
    exec_done   = 1'b1;
    exec_result = v;
    @(negedge clk);
    exec_done   = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exec_start) n_start++;
    if (result_valid) begin
      if (sbq.size() == 0) begin
        chk("rv_unexpected", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_sign", {63'd0, sign}, {63'd0, e.sgn});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k;
    clk = 0; rst = 0; confirm = 0; switches = '0; exec_done = 0; exec_result = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_outs", {57'd0, exec_start, result_valid, sign, error, busy, exec_mode == 0, exec_op == 0},
        {57'd0, 7'b0000011});
    chk("rst_ops", opa | opb, 0);
    rst = 1;

    // 16-bit arithmetic add
    setup(16'd1, 16'd0, 16'd0);
    press(16'h0005);
    chk("t1_no_start", {63'd0, exec_start}, 64'd0);
    press(16'h0003);
    chk("t1_start", {63'd0, exec_start}, 64'd1);
    chk("t1_opa", opa, 64'd5);
    chk("t1_opb", opb, 64'd3);
    chk("t1_mode", {58'd0, exec_mode, exec_op}, {58'd0, 3'd1, 3'd0});
    @(negedge clk);
    chk("t1_start_1cyc", {63'd0, exec_start}, 64'd0);
    push(64'd8, 1'b0);
    done_pulse(64'd8);
    chk("t1_rv_early", {63'd0, result_valid}, 64'd0);
    @(negedge clk);
    chk("t1_rv", {63'd0, result_valid}, 64'd1);
    @(negedge clk);
    chk("t1_rv_pulse", {63'd0, result_valid}, 64'd0);

    // 64-bit operands
    setup(16'd0, 16'd0, 16'd3);
    press(16'h1111); press(16'h2222); press(16'h3333); press(16'h8444);
    chk("t2_opa", opa, 64'h8444333322221111);
    press(16'h0001); press(16'h0000); press(16'h0000); press(16'h0000);
    chk("t2_start", {63'd0, exec_start}, 64'd1);
    chk("t2_opb", opb, 64'd1);
    push(64'h8444333322221111, 1'b1);
    done_pulse(64'h8444333322221111);
    repeat (2) @(negedge clk);

    // Store then fetch through the register file
    @(negedge clk);
    s0 = n_start;
    setup(16'd5, 16'd2, 16'd0);
    press(16'hBEEF);
    chk("t3_opa", opa, act16(16'hBEEF));
    push(act16(16'hBEEF), 1'b1);
    @(negedge clk);
    chk("t3_store_rv", {63'd0, result_valid}, 64'd1);
    setup(16'd4, 16'd2, 16'd0);
    press(16'h0000);
    push(act16(16'hBEEF), 1'b1);
    repeat (2) @(negedge clk);
    setup(16'd4, 16'd1, 16'd0);
    press(16'h0000);
    push(64'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("t3_no_exec", n_start, s0);

    // Unary logic NOT skips operand B
    setup(16'd3, 16'd6, 16'd0);
    press(16'h00F0);
    chk("t4_start", {63'd0, exec_start}, 64'd1);
    chk("t4_opb", opb, 64'd0);
    chk("t4_mode", {58'd0, exec_mode, exec_op}, {58'd0, 3'd3, 3'd6});
    push(64'hFF0F, 1'b1);
    @(negedge clk);
    done_pulse(64'hFFFF_FFFF_FFFF_FF0F);
    repeat (2) @(negedge clk);

    // Timeout with done withheld
    setup(16'd1, 16'd0, 16'd0);
    press(16'h0001);
    press(16'h0002);
    chk("t5_start", {63'd0, exec_start}, 64'd1);
    k = 0;
    while (!error && k < TO + 10) begin
      @(negedge clk);
      k++;
    end
    chk("t5_cycles", k, TO + 1);
    chk("t5_error", {63'd0, error}, 64'd1);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_result_kept", result, 64'hFF0F);
    press(16'd1);
    chk("t5_err_clear", {63'd0, error}, 64'd0);
    press(16'd0); press(16'd0); press(16'd7); press(16'd7);
    chk("t5_resume_start", {63'd0, exec_start}, 64'd1);
    push(64'd14, 1'b0);
    done_pulse(64'd14);
    repeat (2) @(negedge clk);

    // Illegal modes
    press(16'd7);
    chk("t6_illegal7", {62'd0, error, busy}, {62'd0, 2'b10});
    press(16'd6);
    chk("t6_illegal6", {63'd0, error}, 64'd1);
    press(16'd3);
    chk("t6_clear", {63'd0, error}, 64'd0);

    // Confirms ignored in WAIT, then reset aborts
    press(16'd0); press(16'd0); press(16'h0055); press(16'h00AA);
    @(negedge clk);
    s0 = n_start;
    press(16'h0003); press(16'h0001);
    chk("t7_busy", {63'd0, busy}, 64'd1);
    chk("t7_no_restart", n_start, s0);
    rst = 0;
    #1;
    chk("t7_rst_result", result, 0);
    chk("t7_rst_outs", {58'd0, exec_start, result_valid, sign, error, busy, exec_mode == 0},
        {58'd0, 6'b000001});
    chk("t7_rst_ops", opa | opb, 0);
    @(negedge clk);
    rst = 1;
    setup(16'd4, 16'd2, 16'd0);
    press(16'h0000);
    push(64'd0, 1'b0);
    repeat (2) @(negedge clk);

    // Extension of a 16-bit negative operand
    setup(16'd1, 16'd0, 16'd0);
    press(16'h8001);
    press(16'h0001);
    chk("t8_opa_ext", opa, act16(16'h8001));
    push(64'h8002, 1'b1);
    done_pulse(64'h8002);
    repeat (3) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
